// File: rtl/cmd_pkg.sv
// Shared channel map, command vector type and priority helper for the
// vacuum-cleaner command conditioner.
package cmd_pkg;

  localparam int N_CH = 4;

  typedef logic [3:0] cmd_vec_t;
  typedef logic [1:0] ch_idx_t;

  localparam ch_idx_t CH_POWER_OFF = 2'd0;
  localparam ch_idx_t CH_ON        = 2'd1;
  localparam ch_idx_t CH_CLEANING  = 2'd2;
  localparam ch_idx_t CH_EVADING   = 2'd3;

  // Highest priority first.
  localparam ch_idx_t PRIO_ORDER [N_CH] = '{CH_POWER_OFF, CH_EVADING, CH_CLEANING, CH_ON};

  // Walk from lowest to highest priority so the last hit wins.
  function automatic cmd_vec_t prio_encode(cmd_vec_t lvl);
    cmd_vec_t res;
    res = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (lvl[PRIO_ORDER[i]]) begin
        res = '0;
        res[PRIO_ORDER[i]] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cmd_conditioner_if.sv
// Switch-in / command-out bundle of the command conditioner.
interface cmd_conditioner_if;
  import cmd_pkg::*;

  cmd_vec_t sw_in;
  cmd_vec_t sw_deb_o;
  cmd_vec_t cmd_o;
  logic     cmd_chg_o;

  modport master (output sw_in, input sw_deb_o, input cmd_o, input cmd_chg_o);
  modport slave  (input sw_in, output sw_deb_o, output cmd_o, output cmd_chg_o);

endinterface

// File: rtl/debounce_bit.sv
// One switch channel: 2-flop synchroniser followed by a counting debouncer
// that accepts a new level after DEBOUNCE_CYCLES identical samples.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_deb
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_deb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_deb  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      // Any sample matching the accepted level restarts the run.
      if (r_sync[1] == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_deb <= r_sync[1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/cmd_conditioner.sv
// Debounces the four slide switches and resolves them by fixed priority into a
// registered one-hot-or-zero command with a one-cycle change strobe.
module cmd_conditioner
  import cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic              clk,
  input logic              rst_n,
  cmd_conditioner_if.slave cmd_if
);

  cmd_vec_t w_deb;
  cmd_vec_t w_cmd;
  cmd_vec_t r_cmd;
  logic     r_cmd_chg;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_raw (cmd_if.sw_in[g]),
      .o_deb (w_deb[g])
    );
  end

  assign w_cmd = prio_encode(w_deb);

  // Strobe compares against the held command so masked switch changes stay silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd     <= '0;
      r_cmd_chg <= 1'b0;
    end else begin
      r_cmd     <= w_cmd;
      r_cmd_chg <= (w_cmd != r_cmd);
    end
  end

  assign cmd_if.sw_deb_o  = w_deb;
  assign cmd_if.cmd_o     = r_cmd;
  assign cmd_if.cmd_chg_o = r_cmd_chg;

endmodule

// File: tb/tb_cmd_conditioner.sv
// Directed bench for cmd_conditioner with DEBOUNCE_CYCLES=4: expected command
// changes are queued at drive time and popped when the change strobe fires.
module tb_cmd_conditioner;
  import cmd_pkg::*;

  localparam int unsigned DC  = 4;
  localparam int          LAT = DC + 3;

  typedef struct {
    cmd_vec_t deb;
    cmd_vec_t cmd;
    int       lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];

  cmd_conditioner_if tb_if ();

  cmd_conditioner #(
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd_if (tb_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input cmd_vec_t deb, input cmd_vec_t cmd, input int lat);
    exp_t e;
    e.deb = deb;
    e.cmd = cmd;
    e.lat = lat;
    sb_q.push_back(e);
  endtask

  // start = edges already elapsed since the stimulus for the queued entry.
  task automatic await_chg(input string tag, input int start);
    exp_t e;
    int   n;
    bit   seen;
    e    = sb_q[0];
    n    = start;
    seen = 1'b0;
    while (!seen && n < start + 30) begin
      @(negedge clk);
      n++;
      if (n == e.lat - 1) check({tag, ":deb"}, 32'(tb_if.sw_deb_o), 32'(e.deb));
      if (tb_if.cmd_chg_o) seen = 1'b1;
    end
    check({tag, ":seen"}, 32'(seen), 32'd1);
    void'(sb_q.pop_front());
    check({tag, ":lat"}, 32'(n), 32'(e.lat));
    check({tag, ":cmd"}, 32'(tb_if.cmd_o), 32'(e.cmd));
    @(negedge clk);
    check({tag, ":pulse1"}, 32'(tb_if.cmd_chg_o), 32'd0);
    check({tag, ":hold"}, 32'(tb_if.cmd_o), 32'(e.cmd));
  endtask

  task automatic hold_quiet(input string tag, input int n, input cmd_vec_t cmd,
                            input cmd_vec_t deb);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, ":chg"}, 32'(tb_if.cmd_chg_o), 32'd0);
      check({tag, ":cmd"}, 32'(tb_if.cmd_o), 32'(cmd));
    end
    check({tag, ":deb"}, 32'(tb_if.sw_deb_o), 32'(deb));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":cmd"}, 32'(tb_if.cmd_o), 32'd0);
    check({tag, ":deb"}, 32'(tb_if.sw_deb_o), 32'd0);
    check({tag, ":chg"}, 32'(tb_if.cmd_chg_o), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    tb_if.sw_in = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero("in_reset");
    end

    // Switches already high at release still need the full debounce.
    rst_n = 1'b1;
    push_exp(4'b1111, 4'b0001, LAT);
    await_chg("rst_release", 0);

    tb_if.sw_in = 4'b0000;
    push_exp(4'b0000, 4'b0000, LAT);
    await_chg("all_off", 0);

    tb_if.sw_in = 4'b0010;
    push_exp(4'b0010, 4'b0010, LAT);
    await_chg("on", 0);

    // 3-cycle glitch on cleaning is rejected.
    tb_if.sw_in = 4'b0110;
    hold_quiet("glitch3_hi", 3, 4'b0010, 4'b0010);
    tb_if.sw_in = 4'b0010;
    hold_quiet("glitch3_lo", 10, 4'b0010, 4'b0010);

    // 4-cycle pulse is accepted, then the low level is debounced back.
    tb_if.sw_in = 4'b0110;
    push_exp(4'b0110, 4'b0100, LAT);
    hold_quiet("pulse4_hi", 4, 4'b0010, 4'b0010);
    tb_if.sw_in = 4'b0010;
    await_chg("pulse4_acc", 4);
    push_exp(4'b0010, 4'b0010, 4 + LAT);
    await_chg("pulse4_back", LAT + 1);

    tb_if.sw_in = 4'b0110;
    push_exp(4'b0110, 4'b0100, LAT);
    await_chg("prio_clean", 0);

    tb_if.sw_in = 4'b1110;
    push_exp(4'b1110, 4'b1000, LAT);
    await_chg("prio_evade", 0);

    tb_if.sw_in = 4'b1111;
    push_exp(4'b1111, 4'b0001, LAT);
    await_chg("prio_power", 0);

    // Masked lower-priority toggles move sw_deb_o but not cmd_o.
    tb_if.sw_in = 4'b1101;
    hold_quiet("mask_on_lo", 10, 4'b0001, 4'b1101);
    tb_if.sw_in = 4'b1111;
    hold_quiet("mask_on_hi", 10, 4'b0001, 4'b1111);

    tb_if.sw_in = 4'b0000;
    push_exp(4'b0000, 4'b0000, LAT);
    await_chg("release_all", 0);

    // Reset with a partial count (cnt=2) on cleaning.
    tb_if.sw_in = 4'b0100;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid_deb");
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(4'b0100, 4'b0100, LAT);
    await_chg("after_rst_deb", 0);

    // Asynchronous reset while a command is active.
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid_act");
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(4'b0100, 4'b0100, LAT);
    await_chg("after_rst_act", 0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_conditioner.md
Name: cmd_conditioner

Overview:
Upstream input stage for the vacuum-cleaner Moore FSM. It synchronises the four raw slide-switch commands from ui_in[3:0] (power_off, on, cleaning, evading) and debounces each one. It then resolves them by fixed priority into a registered one-hot-or-zero command vector that the FSM consumes directly. It also emits a one-cycle change strobe for logging and for LED blink logic.

Parameters:
N_CH, 4, number of switch channels (fixed at 4 for this design; the parameter is kept for the sub-module)
DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples needed to accept a new level; legal range 1..65535
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
sw_in  input  4  raw switches: [0]=power_off, [1]=on, [2]=cleaning, [3]=evading
sw_deb_o  output  4  debounced switch levels, before priority resolution
cmd_o  output  4  registered priority-resolved command, one-hot or all-zero, same bit mapping as sw_in
cmd_chg_o  output  1  one-cycle pulse when cmd_o takes a new value

Behaviour:
- Reset: when rst_n=0, all flops clear immediately, without waiting for a clock edge.
  - Cleared state: sync stages, debounce counters, sw_deb_o=0, cmd_o=0, cmd_chg_o=0.
  - After reset release, switches already held high are treated as new transitions and go through the full debounce.
- Synchroniser: 2-flop chain per bit, reset value 0.
- Debounce, per channel, independent of the other channels:
  - State is a level register deb (reset 0) and a counter cnt (reset 0).
  - If sync bit == deb: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: deb <= sync bit, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A single sample equal to deb restarts the count, so glitches shorter than DEBOUNCE_CYCLES samples are rejected.
  - cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- Priority encoder: power_off > evading > cleaning > on.
  - cmd_o has at most one bit set: the highest-priority set bit of sw_deb_o.
  - cmd_o = 0 when sw_deb_o = 0.
- Registering and latency:
  - cmd_o is registered one cycle after sw_deb_o.
  - Counting the first rising edge that samples a stable new raw value as edge 1:
    - sw_deb_o changes after edge DEBOUNCE_CYCLES+2.
    - cmd_o changes after edge DEBOUNCE_CYCLES+3.
- cmd_chg_o:
  - High for exactly the cycle in which cmd_o differs from its previous value, including a change to zero.
  - Registered alongside cmd_o.
  - Not asserted for a debounced change that leaves cmd_o unchanged, e.g. a lower-priority switch toggling while power_off is held.
- Simultaneous events:
  - Several channels accepting new levels on the same edge are resolved by priority in the same cmd_o update.
  - This produces one cmd_chg_o pulse, not one per channel.
- Reset mid-debounce: partial counts are discarded; there is no residual state.
- Mid-operation, sw_in is assumed asynchronous; no setup or hold relation to clk is required.

Decomposition:
- Package cmd_pkg holds:
  - Channel indices CH_POWER_OFF=0, CH_ON=1, CH_CLEANING=2, CH_EVADING=3.
  - A typedef cmd_vec_t (logic [3:0]).
  - The priority-order constant used by the encoder.
- Sub-module debounce_bit: one synchroniser, counter and level for one channel, parameterised by DEBOUNCE_CYCLES, instantiated N_CH times.
- cmd_conditioner holds the generate loop, the priority encoder, the output registers and the change detector.

Test Plan (DEBOUNCE_CYCLES=4, so cmd_o latency = 7 edges):
- Reset with sw_in=4'b1111 held throughout → cmd_o=0, sw_deb_o=0 during reset; after release, cmd_o=4'b0001 after edge 7, with cmd_chg_o high for that one cycle.
- From idle, sw_in=4'b0010 stable → sw_deb_o=4'b0010 after edge 6, cmd_o=4'b0010 after edge 7, one cmd_chg_o pulse.
- Glitch: sw_in[2] high for 3 cycles, then low → sw_deb_o and cmd_o unchanged, no cmd_chg_o. Repeat with 4 cycles high → accepted, cmd_o=4'b0100, then returns to the prior value after the low level has been held for 4 cycles.
- Priority:
  - sw_in=4'b0110 → cmd_o=4'b0100.
  - Set sw_in[3] → cmd_o=4'b1000.
  - Set sw_in[0] → cmd_o=4'b0001.
  - Toggle sw_in[1] while bit 0 is held → sw_deb_o follows, cmd_o stays 4'b0001, no cmd_chg_o.
- Release all switches from cmd_o=4'b0001 → cmd_o=4'b0000 after 7 edges, with one cmd_chg_o pulse.
- Drop rst_n asynchronously mid-debounce (cnt=2) and mid-active (cmd_o=4'b0100) → all outputs 0 before the next clk edge; after release, a full 7-edge latency is required again.
